// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, ALU codes, FSM states and mux encodings for the multicycle controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ERROR
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// riscv_alu_decoder: maps ALUOp/funct3/funct7b5/op5 to the 3-bit ALUControl code and flags unsupported functs.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       illegal_funct
);

    logic [2:0] funct_ctl;

    always_comb begin
        funct_ctl = ALU_ADD;
        case (funct3)
            3'b000:  funct_ctl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_ctl = ALU_SLL;
            3'b011:  funct_ctl = ALU_SLT;
            3'b100:  funct_ctl = ALU_XOR;
            3'b101:  funct_ctl = ALU_SRL;
            3'b110:  funct_ctl = ALU_OR;
            3'b111:  funct_ctl = ALU_AND;
            default: funct_ctl = ALU_ADD;
        endcase
    end

    assign alu_control = alu_op == ALUOP_ADD ? ALU_ADD : alu_op == ALUOP_SUB ? ALU_SUB : funct_ctl;

    assign illegal_funct = alu_op == ALUOP_FUNCT &&
        (funct3 == 3'b010 || (funct3 == 3'b101 && funct7b5) ||
         (op5 && funct7b5 && funct3 != 3'b000 && funct3 != 3'b101));

endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RISC-V control FSM driving datapath selects, strobes and ALUControl.
// Define RISCV_CTRL_BNE_EN to also accept bne (branch funct3 001, taken when Zero=0).
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_t state, next;
    aluop_t alu_op;
    logic   pc_update, branch, ir_write, reg_write, mem_write;
    logic   illegal_funct, bad_branch, take;

`ifdef RISCV_CTRL_BNE_EN
    assign bad_branch = funct3[2:1] != 2'b00;
    assign take       = branch & (Zero ^ funct3[0]);
`else
    assign bad_branch = funct3 != 3'b000;
    assign take       = branch & Zero;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RESET_STATE;
        else        state <= next;

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = DECODE;
            DECODE:   next = (op == OP_LW || op == OP_SW) ? MEMADR :
                             op == OP_R                   ? EXECUTER :
                             op == OP_I                   ? EXECUTEI :
                             (op == OP_BEQ && !bad_branch) ? BEQ :
                             op == OP_JAL                 ? JAL : ERROR;
            MEMADR:   next = op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  next = MEMWB;
            EXECUTER,
            EXECUTEI: next = illegal_funct ? ERROR : ALUWB;
            JAL:      next = ALUWB;
            ERROR:    next = ERROR;
            default:  next = FETCH;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state)
            FETCH:    begin ir_write = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT; pc_update = 1'b1; end
            DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
            MEMADR:   begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = RES_DATA; reg_write = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; end
            EXECUTER: begin ALUSrcA = SRCA_RS1; alu_op = ALUOP_FUNCT; end
            EXECUTEI: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; alu_op = ALUOP_FUNCT; end
            ALUWB:    reg_write = 1'b1;
            BEQ:      begin ALUSrcA = SRCA_RS1; alu_op = ALUOP_SUB; branch = 1'b1; end
            JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; pc_update = 1'b1; end
            default:  ;
        endcase
    end

    riscv_alu_decoder u_dec (
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .op5          (op[5]),
        .alu_control  (ALUControl),
        .illegal_funct(illegal_funct)
    );

    // strobes drop the instant reset asserts, before the state register is observed
    assign PCWrite  = rst_n & (pc_update | take);
    assign IRWrite  = rst_n & ir_write;
    assign RegWrite = rst_n & reg_write;
    assign MemWrite = rst_n & mem_write;
    assign ImmSrc   = imm_src(op);
    assign illegal  = state == ERROR;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: table-driven per-cycle checks of the multicycle controller plus a mid-instruction reset sequence.
module tb_riscv_mc_controller;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
    localparam logic [16:0] ALL = '1;
    localparam logic [16:0] NOALU = 17'h1FFF1;

    logic clk = 1'b0, rst_n = 1'b0, funct7b5 = 1'b0, Zero = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [16:0] act;
    int passed = 0, total = 0;

    typedef struct {
        logic        r;
        logic [6:0]  o;
        logic [2:0]  f;
        logic        s;
        logic        z;
        logic [16:0] e;
        logic [16:0] m;
    } vec_t;
    vec_t v[$];

    riscv_mc_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    function automatic logic [16:0] w(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                      logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                      logic [1:0] imm, logic [2:0] alu, logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [16:0] fe(logic [1:0] imm);
        return w(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic logic [16:0] de(logic [1:0] imm);
        return w(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    endfunction

    function automatic logic [16:0] wb(logic [1:0] imm);
        return w(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction

    function automatic logic [16:0] er(logic [1:0] imm);
        return w(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
    endfunction

    function automatic logic [16:0] rs_w(logic [1:0] imm);
        return w(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic void add(logic r, logic [6:0] o, logic [2:0] f, logic s, logic z,
                                logic [16:0] e, logic [16:0] m = ALL);
        v.push_back('{r, o, f, s, z, e, m});
    endfunction

    task automatic check(string name, logic [16:0] e, logic [16:0] m);
        total++;
        if ((act & m) !== (e & m))
            $display("FAIL %s: got %017b expected %017b (mask %017b)", name, act, e, m);
        else
            passed++;
    endtask

    initial begin
        // reset held: strobes low, FETCH selects
        add(0, RT, 3'b000, 1, 0, rs_w(2'b00));
        // R-type sub: 4 cycles
        add(1, RT, 3'b000, 1, 0, fe(2'b00));
        add(1, RT, 3'b000, 1, 0, de(2'b00));
        add(1, RT, 3'b000, 1, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
        add(1, RT, 3'b000, 1, 0, wb(2'b00));
        // R-type and
        add(1, RT, 3'b111, 0, 0, fe(2'b00));
        add(1, RT, 3'b111, 0, 0, de(2'b00));
        add(1, RT, 3'b111, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 0));
        add(1, RT, 3'b111, 0, 0, wb(2'b00));
        // lw: 5 cycles
        add(1, LW, 3'b010, 0, 0, fe(2'b00));
        add(1, LW, 3'b010, 0, 0, de(2'b00));
        add(1, LW, 3'b010, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        add(1, LW, 3'b010, 0, 0, w(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        add(1, LW, 3'b010, 0, 0, w(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        // sw: 4 cycles
        add(1, SW, 3'b010, 0, 0, fe(2'b01));
        add(1, SW, 3'b010, 0, 0, de(2'b01));
        add(1, SW, 3'b010, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        add(1, SW, 3'b010, 0, 0, w(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        // beq taken and not taken: 3 cycles each
        add(1, BR, 3'b000, 0, 1, fe(2'b10));
        add(1, BR, 3'b000, 0, 1, de(2'b10));
        add(1, BR, 3'b000, 0, 1, w(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        add(1, BR, 3'b000, 0, 0, fe(2'b10));
        add(1, BR, 3'b000, 0, 0, de(2'b10));
        add(1, BR, 3'b000, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        // slli, srli
        add(1, IT, 3'b001, 0, 0, fe(2'b00));
        add(1, IT, 3'b001, 0, 0, de(2'b00));
        add(1, IT, 3'b001, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b110, 0));
        add(1, IT, 3'b001, 0, 0, wb(2'b00));
        add(1, IT, 3'b101, 0, 0, fe(2'b00));
        add(1, IT, 3'b101, 0, 0, de(2'b00));
        add(1, IT, 3'b101, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b111, 0));
        add(1, IT, 3'b101, 0, 0, wb(2'b00));
        // jal: 4 cycles
        add(1, JL, 3'b000, 0, 0, fe(2'b11));
        add(1, JL, 3'b000, 0, 0, de(2'b11));
        add(1, JL, 3'b000, 0, 0, w(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
        add(1, JL, 3'b000, 0, 0, wb(2'b11));
        // I-type funct3 010 -> ERROR, held until reset
        add(1, IT, 3'b010, 0, 0, fe(2'b00));
        add(1, IT, 3'b010, 0, 0, de(2'b00));
        add(1, IT, 3'b010, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), NOALU);
        add(1, IT, 3'b010, 0, 0, er(2'b00));
        add(1, IT, 3'b010, 0, 0, er(2'b00));
        add(1, IT, 3'b010, 0, 0, er(2'b00));
        add(0, IT, 3'b010, 0, 0, rs_w(2'b00));
        // branch funct3 001 without the bne option -> ERROR from DECODE
        add(1, BR, 3'b001, 0, 0, fe(2'b10));
        add(1, BR, 3'b001, 0, 0, de(2'b10));
        add(1, BR, 3'b001, 0, 0, er(2'b10));
        add(0, BR, 3'b001, 0, 0, rs_w(2'b10));
        // R-type xor with funct7b5 set -> ERROR after EXECUTER
        add(1, RT, 3'b100, 1, 0, fe(2'b00));
        add(1, RT, 3'b100, 1, 0, de(2'b00));
        add(1, RT, 3'b100, 1, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0), NOALU);
        add(1, RT, 3'b100, 1, 0, er(2'b00));
        add(0, RT, 3'b100, 1, 0, rs_w(2'b00));
        // unknown opcode -> ERROR from DECODE
        add(1, BAD, 3'b000, 0, 0, fe(2'b00));
        add(1, BAD, 3'b000, 0, 0, de(2'b00));
        add(1, BAD, 3'b000, 0, 0, er(2'b00));
        add(0, BAD, 3'b000, 0, 0, rs_w(2'b00));
        // sw up to MEMWRITE, then reset mid-instruction below
        add(1, SW, 3'b010, 0, 0, fe(2'b01));
        add(1, SW, 3'b010, 0, 0, de(2'b01));
        add(1, SW, 3'b010, 0, 0, w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        add(1, SW, 3'b010, 0, 0, w(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));

        foreach (v[i]) begin
            @(negedge clk);
            rst_n = v[i].r; op = v[i].o; funct3 = v[i].f; funct7b5 = v[i].s; Zero = v[i].z;
            #1;
            check($sformatf("vec%0d", i), v[i].e, v[i].m);
        end

        // still inside MEMWRITE: MemWrite must fall as soon as rst_n does
        #2 rst_n = 1'b0;
        #1 check("memwrite_abort", rs_w(2'b01), ALL);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("fetch_after_abort", fe(2'b01), ALL);
        @(posedge clk);
        #1 check("decode_after_abort", de(2'b01), ALL);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
